mem_lsu: RTL and testbench

- Memory-stage load/store unit. It is the consumer end of the EX/MEM pipeline register.
- It takes the registered mem_* signals and performs data-RAM accesses over a req/ack handshake.
- It raises stallreq toward pipeline control until the access completes.
- It registers the write-back triple (wb_wd, wb_wreg, wb_wdata) toward the register file. Byte lanes are MIPS big-endian.

---
 rtl/mem_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a req/ack data-RAM port from the EX/MEM register and registers the write-back triple.
// Latency 1 cycle for non-memory ops, >=2 cycles for RAM accesses (stallreq held until ack); big-endian byte lanes.
module mem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_sdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic              stallreq,
  output logic              misalign,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] OP_LB  = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW  = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  state_t              state_q, state_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [3:0]          ram_sel_q, ram_sel_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic [4:0]          wb_wd_q, wb_wd_d;
  logic                wb_wreg_q, wb_wreg_d;
  logic [31:0]         wb_wdata_q, wb_wdata_d;
  logic                misalign_q, misalign_d;
  logic [3:0]          op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [4:0]          wd_q, wd_d;
  logic                wreg_q, wreg_d;

  logic                is_byte, is_half, is_word, is_store, is_mem, is_mis;
  logic [1:0]          off;
  logic [3:0]          sel;
  logic [31:0]         sdata_rep;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_data;

  assign off      = mem_addr[1:0];
  assign is_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
  assign is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
  assign is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
  assign is_store = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
  assign is_mem   = is_byte || is_half || is_word;
  assign is_mis   = (is_half && off[0]) || (is_word && (off != 2'b00));

  always_comb begin
    sel       = 4'b1111;
    sdata_rep = mem_sdata;
    if (is_byte) begin
      sel       = 4'b1000 >> off;
      sdata_rep = {4{mem_sdata[7:0]}};
    end else if (is_half) begin
      sel       = off[1] ? 4'b0011 : 4'b1100;
      sdata_rep = {2{mem_sdata[15:0]}};
    end
  end

  // Lane extraction uses the op/offset latched at issue, not the live mem_* inputs.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = ram_rdata[31:24];
      2'd1:    ld_byte = ram_rdata[23:16];
      2'd2:    ld_byte = ram_rdata[15:8];
      default: ld_byte = ram_rdata[7:0];
    endcase
    ld_half = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = ram_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    wb_wd_d     = wb_wd_q;
    wb_wreg_d   = wb_wreg_q;
    wb_wdata_d  = wb_wdata_q;
    misalign_d  = 1'b0;
    op_d        = op_q;
    off_d       = off_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    stallreq    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          wb_wd_d    = mem_wd;
          wb_wreg_d  = mem_wreg;
          wb_wdata_d = mem_wdata;
        end else if (is_mis) begin
          misalign_d = 1'b1;
          wb_wd_d    = 5'd0;
          wb_wreg_d  = 1'b0;
          wb_wdata_d = 32'd0;
        end else begin
          stallreq   = 1'b1;
          ram_req_d  = 1'b1;
          ram_we_d   = is_store;
          ram_addr_d = {mem_addr[ADDR_W-1:2], 2'b00};
          ram_sel_d  = sel;
          if (is_store) ram_wdata_d = sdata_rep;
          op_d       = mem_op;
          off_d      = off;
          wd_d       = mem_wd;
          wreg_d     = mem_wreg;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!ram_ack) begin
          stallreq = 1'b1;
        end else begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          ram_sel_d = 4'd0;
          state_d   = IDLE;
          if (ram_we_q) begin
            wb_wd_d    = 5'd0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = 32'd0;
          end else begin
            wb_wd_d    = wd_q;
            wb_wreg_d  = wreg_q;
            wb_wdata_d = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // No stall is requested while reset is asserted.
    if (!rst) stallreq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= 4'd0;
      ram_wdata_q <= 32'd0;
      wb_wd_q     <= 5'd0;
      wb_wreg_q   <= 1'b0;
      wb_wdata_q  <= 32'd0;
      misalign_q  <= 1'b0;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      wb_wd_q     <= wb_wd_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_wdata_q  <= wb_wdata_d;
      misalign_q  <= misalign_d;
      op_q        <= op_d;
      off_q       <= off_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;
  assign misalign  = misalign_q;
  assign wb_wd     = wb_wd_q;
  assign wb_wreg   = wb_wreg_q;
  assign wb_wdata  = wb_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a write-back scoreboard.
module tb_mem_lsu;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stallreq, misalign;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int  checks = 0;
  int  errors = 0;
  wb_t sb[$];
  wb_t last_wb;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stallreq(stallreq), .misalign(misalign),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input wb_t exp);
    chk({tag, ".wd"},    {27'd0, wb_wd},   {27'd0, exp.wd});
    chk({tag, ".wreg"},  {31'd0, wb_wreg}, {31'd0, exp.wreg});
    chk({tag, ".wdata"}, wb_wdata,         exp.wdata);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".req"},   {31'd0, ram_req},  32'd0);
    chk({tag, ".we"},    {31'd0, ram_we},   32'd0);
    chk({tag, ".addr"},  ram_addr,          32'd0);
    chk({tag, ".sel"},   {28'd0, ram_sel},  32'd0);
    chk({tag, ".rwd"},   ram_wdata,         32'd0);
    chk({tag, ".stall"}, {31'd0, stallreq}, 32'd0);
    chk({tag, ".mis"},   {31'd0, misalign}, 32'd0);
  endtask

  // One aligned RAM access: issue, hold for `waits` unacked WAIT cycles, ack, then score write-back.
  task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] rdata, input int waits, input logic [3:0] exp_sel,
                        input logic [31:0] exp_rwd, input logic exp_we, input wb_t exp_wb);
    wb_t got;
    mem_op = op; mem_addr = addr; mem_sdata = sdata;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = 32'h0BAD0BAD; ram_ack = 1'b0;
    sb.push_back(exp_wb);
    #1;
    chk({tag, ".stall_issue"}, {31'd0, stallreq}, 32'd1);
    step();
    chk({tag, ".req"},  {31'd0, ram_req}, 32'd1);
    chk({tag, ".we"},   {31'd0, ram_we},  {31'd0, exp_we});
    chk({tag, ".addr"}, ram_addr,         addr & 32'hFFFF_FFFC);
    chk({tag, ".sel"},  {28'd0, ram_sel}, {28'd0, exp_sel});
    chk({tag, ".mis"},  {31'd0, misalign}, 32'd0);
    if (exp_we) chk({tag, ".rwd"}, ram_wdata, exp_rwd);
    chk_wb({tag, ".hold"}, last_wb);
    for (int i = 0; i < waits; i++) begin
      chk({tag, ".stall_wait"}, {31'd0, stallreq}, 32'd1);
      step();
      chk({tag, ".req_wait"}, {31'd0, ram_req}, 32'd1);
    end
    ram_ack = 1'b1; ram_rdata = rdata;
    #1;
    chk({tag, ".stall_ack"}, {31'd0, stallreq}, 32'd0);
    step();
    ram_ack = 1'b0;
    mem_op = 4'd0; mem_wd = exp_wb.wd; mem_wreg = exp_wb.wreg; mem_wdata = exp_wb.wdata;
    chk({tag, ".req_done"}, {31'd0, ram_req}, 32'd0);
    chk({tag, ".sel_done"}, {28'd0, ram_sel}, 32'd0);
    got = sb.pop_front();
    chk_wb({tag, ".wb"}, got);
    last_wb = got;
  endtask

  initial begin
    rst = 1'b0; mem_op = 4'd5; mem_addr = 32'h100; mem_sdata = 32'h0;
    mem_wd = 5'd1; mem_wreg = 1'b1; mem_wdata = 32'hFFFF_FFFF;
    ram_ack = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    step();
    chk_idle_outputs("rst1");
    chk_wb("rst1", '0);
    step();
    chk_idle_outputs("rst2");
    chk_wb("rst2", '0);

    // ALU passthrough
    rst = 1'b1; ram_ack = 1'b0; mem_op = 4'd0;
    mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
    sb.push_back('{wd: 5'd3, wreg: 1'b1, wdata: 32'h1234_5678});
    #1;
    chk("alu.stall", {31'd0, stallreq}, 32'd0);
    step();
    chk("alu.req", {31'd0, ram_req}, 32'd0);
    chk("alu.stall_after", {31'd0, stallreq}, 32'd0);
    last_wb = sb.pop_front();
    chk_wb("alu", last_wb);

    access("lb",  4'd1, 32'h101, 32'h0, 5'd5, 1'b1, 32'h11F0_3344, 3, 4'b0100, 32'h0, 1'b0,
           '{wd: 5'd5, wreg: 1'b1, wdata: 32'hFFFF_FFF0});
    access("lbu", 4'd2, 32'h101, 32'h0, 5'd5, 1'b1, 32'h11F0_3344, 3, 4'b0100, 32'h0, 1'b0,
           '{wd: 5'd5, wreg: 1'b1, wdata: 32'h0000_00F0});
    access("sh",  4'd7, 32'h202, 32'hAAAA_BEEF, 5'd6, 1'b1, 32'h0, 0, 4'b0011, 32'hBEEF_BEEF, 1'b1,
           '{wd: 5'd0, wreg: 1'b0, wdata: 32'h0});
    access("lh",  4'd3, 32'h400, 32'h0, 5'd10, 1'b1, 32'h8001_7FFF, 1, 4'b1100, 32'h0, 1'b0,
           '{wd: 5'd10, wreg: 1'b1, wdata: 32'hFFFF_8001});
    access("sb",  4'd6, 32'h503, 32'h1234_56A5, 5'd11, 1'b1, 32'h0, 2, 4'b0001, 32'hA5A5_A5A5, 1'b1,
           '{wd: 5'd0, wreg: 1'b0, wdata: 32'h0});

    // Misaligned word load is dropped
    mem_op = 4'd5; mem_addr = 32'h106; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h5555_5555;
    ram_ack = 1'b0;
    #1;
    chk("mis.stall", {31'd0, stallreq}, 32'd0);
    step();
    chk("mis.req",  {31'd0, ram_req},  32'd0);
    chk("mis.flag", {31'd0, misalign}, 32'd1);
    last_wb = '0;
    chk_wb("mis", last_wb);
    access("lhu", 4'd4, 32'h106, 32'h0, 5'd8, 1'b1, 32'h0000_FF80, 1, 4'b0011, 32'h0, 1'b0,
           '{wd: 5'd8, wreg: 1'b1, wdata: 32'h0000_FF80});

    // Reset in the middle of a WAIT, late ack ignored
    mem_op = 4'd5; mem_addr = 32'h300; mem_wd = 5'd9; mem_wreg = 1'b1;
    step();
    chk("rstw.req_issue", {31'd0, ram_req}, 32'd1);
    rst = 1'b0;
    step();
    chk("rstw.req_rst", {31'd0, ram_req}, 32'd0);
    chk_wb("rstw.rst", '0);
    rst = 1'b1; mem_op = 4'd0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    ram_ack = 1'b1; ram_rdata = 32'h7777_7777;
    step();
    ram_ack = 1'b0;
    chk("rstw.req_late", {31'd0, ram_req}, 32'd0);
    chk_wb("rstw.late", '0);
    last_wb = '0;
    access("lw", 4'd5, 32'h300, 32'h0, 5'd9, 1'b1, 32'hCAFE_BABE, 1, 4'b1111, 32'h0, 1'b0,
           '{wd: 5'd9, wreg: 1'b1, wdata: 32'hCAFE_BABE});

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb.empty: observed %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
